// File: rtl/imem_loader.sv
// Streams a little-endian word count plus payload bytes into instruction memory,
// holding the CPU in reset meanwhile. Define IMEM_LOADER_CHECKSUM_EN to add a trailing checksum byte.
module imem_loader #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_write_enable,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [IW-1:0] widx_q, widx_d;
  logic [31:0]   nwords_q, nwords_d;
  logic [31:0]   shreg_q, shreg_d;
  logic          ready_q, ready_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          hold_q, hold_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;
`endif

  logic        xfer;
  logic [31:0] assembled;

  // ready_q is high exactly in the byte-accepting states, so it doubles as the state qualifier
  assign xfer      = byte_valid && ready_q;
  assign assembled = {byte_data, shreg_q[31:8]};

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    widx_d   = widx_q;
    nwords_d = nwords_q;
    shreg_d  = shreg_q;
    ready_d  = ready_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    hold_d   = hold_q;
    done_d   = 1'b0;
    err_d    = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d    = sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_HEADER;
          ready_d = 1'b1;
          hold_d  = 1'b1;
          err_d   = 1'b0;
          bcnt_d  = 2'd0;
          widx_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = 8'd0;
`endif
        end
      end
      S_HEADER: begin
        if (xfer) begin
          shreg_d = assembled;
          bcnt_d  = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = sum_q + byte_data;
`endif
          if (bcnt_q == 2'd3) begin
            nwords_d = assembled;
            if (assembled > 32'(DEPTH)) begin
              state_d = S_DONE;
              ready_d = 1'b0;
              done_d  = 1'b1;
              err_d   = 1'b1;
            end else if (assembled == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = S_CHECK;
`else
              state_d = S_DONE;
              ready_d = 1'b0;
              done_d  = 1'b1;
`endif
            end else begin
              state_d = S_PAYLOAD;
            end
          end
        end
      end
      S_PAYLOAD: begin
        if (xfer) begin
          shreg_d = assembled;
          bcnt_d  = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = sum_q + byte_data;
`endif
          if (bcnt_q == 2'd3) begin
            state_d = S_WRITE;
            ready_d = 1'b0;
            we_d    = 1'b1;
            addr_d  = 32'(widx_q) << 2;
            wdata_d = assembled;
          end
        end
      end
      S_WRITE: begin
        // index only advances when another word follows, so it stays within DEPTH-1
        if (32'(widx_q) + 32'd1 < nwords_q) begin
          widx_d  = widx_q + IW'(1);
          state_d = S_PAYLOAD;
          ready_d = 1'b1;
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
          ready_d = 1'b1;
`else
          state_d = S_DONE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (xfer) begin
          if (sum_q + byte_data != 8'd0) err_d = 1'b1;
          state_d = S_DONE;
          ready_d = 1'b0;
          done_d  = 1'b1;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
        hold_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b0;
        hold_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      bcnt_q   <= 2'd0;
      widx_q   <= '0;
      nwords_q <= 32'd0;
      shreg_q  <= 32'd0;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      hold_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q    <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      widx_q   <= widx_d;
      nwords_q <= nwords_d;
      shreg_q  <= shreg_d;
      ready_q  <= ready_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  assign byte_ready       = ready_q;
  assign mem_write_enable = we_q;
  assign mem_addr         = addr_q;
  assign mem_write_data   = wdata_q;
  assign cpu_hold         = hold_q;
  assign done             = done_q;
  assign error            = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Randomized load streams for imem_loader, checked against a queue-based model of
// the expected word writes, write latency, and the done/error outcome.
module tb_imem_loader;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, mem_write_enable, cpu_hold, done, error;
  logic [31:0] mem_addr, mem_write_data;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_write_enable(mem_write_enable), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .cpu_hold(cpu_hold), .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit tog = 1'b0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } wr_t;

  wr_t         wrq[$];
  int          hsq[$];
  logic [31:0] words[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe byte handshakes and memory write strobes once per cycle
  always @(negedge clk) begin
    if (byte_valid && byte_ready) hsq.push_back(cyc);
    if (mem_write_enable) wrq.push_back('{mem_addr, mem_write_data, cyc});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, 32'(byte_ready), 0);
    chk({tag, "_we"},    32'(mem_write_enable), 0);
    chk({tag, "_addr"},  mem_addr, 0);
    chk({tag, "_wdata"}, mem_write_data, 0);
    chk({tag, "_hold"},  32'(cpu_hold), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_error"}, 32'(error), 0);
  endtask

  // mode 0: back-to-back, 1: valid toggles each cycle, 2: random stalls
  task automatic send_byte(input logic [7:0] b, input int mode, input bit st);
    int g = 0;
    bit hs = 1'b0;
    while (!hs && g < 100) begin
      case (mode)
        0:       byte_valid = 1'b1;
        1:       begin tog = ~tog; byte_valid = tog; end
        default: byte_valid = 1'($urandom_range(0, 1));
      endcase
      byte_data = byte_valid ? b : 8'($urandom);
      start = st && (g == 0);
      @(negedge clk);
      hs = byte_valid && byte_ready;
      @(posedge clk);
      #1;
      g++;
    end
    start = 1'b0;
    byte_valid = 1'b0;
    if (!hs) chk("byte_timeout", 0, 1);
  endtask

  // abort_bytes >= 0: stop after that many payload bytes and reset instead of finishing
  task automatic run_load(input string tag, input logic [31:0] n, input int mode,
                          input int start_at, input bit bad_ck, input int abort_bytes);
    logic [7:0] sum = 8'd0;
    logic [7:0] b;
    int idx = 0;
    int nexp;
    bit got = 1'b0;
    bit exp_err;
    wrq.delete();
    hsq.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b = n[8*i +: 8];
      send_byte(b, mode, idx == start_at);
      sum += b;
      idx++;
    end
    if (n <= DEPTH) begin
      for (int k = 0; k < int'(n); k++) begin
        for (int i = 0; i < 4; i++) begin
          if (abort_bytes >= 0 && idx - 4 == abort_bytes) break;
          b = words[k][8*i +: 8];
          send_byte(b, mode, idx == start_at);
          sum += b;
          idx++;
        end
      end
    end
    if (abort_bytes >= 0) begin
      reset = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk_reset_outs({tag, "_rst"});
      chk({tag, "_rst_nwr"}, wrq.size(), abort_bytes / 4);
      reset = 1'b0;
      for (int t = 0; t < 6; t++) begin
        @(negedge clk);
        if (done) got = 1'b1;
      end
      chk({tag, "_no_done"}, 32'(got), 0);
      return;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (n <= DEPTH) send_byte(8'(-sum) + 8'(bad_ck), mode, 1'b0);
`endif
    for (int t = 0; t < 30 && !got; t++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk({tag, "_done"}, 32'(got), 1);
    exp_err = (n > DEPTH);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (bad_ck) exp_err = 1'b1;
`endif
    chk({tag, "_error"}, 32'(error), 32'(exp_err));
    nexp = (n <= DEPTH) ? int'(n) : 0;
    chk({tag, "_nwr"}, wrq.size(), nexp);
    for (int k = 0; k < nexp && k < wrq.size(); k++) begin
      chk({tag, "_addr"}, wrq[k].a, 32'(4 * k));
      chk({tag, "_data"}, wrq[k].d, words[k]);
      if (4 * k + 7 < hsq.size())
        chk({tag, "_lat"}, wrq[k].c, hsq[4 * k + 7] + 1);
      else
        chk({tag, "_hs_count"}, hsq.size(), 4 * k + 8);
    end
    @(negedge clk);
    chk({tag, "_hold_after"},  32'(cpu_hold), 0);
    chk({tag, "_ready_after"}, 32'(byte_ready), 0);
    chk({tag, "_done_once"},   32'(done), 0);
    chk({tag, "_err_hold"},    32'(error), 32'(exp_err));
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int k = 0; k < n; k++) words.push_back($urandom);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk_reset_outs("reset");
    reset = 1'b0;

    words.delete();
    words.push_back(32'h005303b3);
    run_load("basic", 32'd1, 0, -1, 1'b0, -1);

    rand_words(3);
    run_load("toggle", 32'd3, 1, -1, 1'b0, -1);

    run_load("too_big", 32'd65, 0, -1, 1'b0, -1);
    run_load("huge", 32'h0100_0000, 2, -1, 1'b0, -1);
    run_load("zero", 32'd0, 0, -1, 1'b0, -1);

    rand_words(4);
    run_load("abort", 32'd4, 0, -1, 1'b0, 8);
    rand_words(4);
    run_load("after_abort", 32'd4, 2, -1, 1'b0, -1);

    rand_words(2);
    run_load("start_mid", 32'd2, 0, 6, 1'b0, -1);

    rand_words(DEPTH);
    run_load("full", 32'(DEPTH), 0, -1, 1'b0, -1);

    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(1, 8);
      rand_words(n);
      run_load("random", 32'(n), 2, -1, 1'b0, -1);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    words.delete();
    words.push_back(32'h005303b3);
    run_load("bad_ck", 32'd1, 0, -1, 1'b1, -1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64: instruction memory capacity in 32-bit words.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 SHALL have port start  input  1  single-cycle request to begin a load; honoured only in IDLE.
REQ-005 SHALL have port byte_valid  input  1  byte_data is valid this cycle.
REQ-006 SHALL have port byte_data  input  8  incoming stream byte.
REQ-007 SHALL have port byte_ready  output  1  loader accepts a byte this cycle; a byte transfers when byte_valid and byte_ready are both high.
REQ-008 SHALL have port mem_write_enable  output  1  one-cycle instruction memory write strobe.
REQ-009 SHALL have port mem_addr  output  32  word-aligned byte address of the write.
REQ-010 SHALL have port mem_write_data  output  32  word written.
REQ-011 SHALL have port cpu_hold  output  1  high whenever the state is not IDLE; holds the CPU in reset.
REQ-012 SHALL have port done  output  1  one-cycle pulse at end of load, success or failure.
REQ-013 SHALL have port error  output  1  failure flag, valid from the done pulse until the next accepted start.

Function
REQ-014 SHALL implement states IDLE, HEADER, PAYLOAD, WRITE, CHECK (checksum build only), DONE.
REQ-015 IDLE: byte_ready=0; start=1 -> HEADER, clears error, byte and word counters; start in any other state ignored.
REQ-016 HEADER: byte_ready=1; accepts 4 bytes forming word count N, little-endian (first byte = bits 7:0).
REQ-017 After the 4th header byte: N > DEPTH -> DONE with error=1, no memory writes; N == 0 -> CHECK if checksum built, else DONE; otherwise -> PAYLOAD.
REQ-018 PAYLOAD: byte_ready=1; assembles each word little-endian; after 4th byte -> WRITE.
REQ-019 WRITE: lasts exactly one cycle; byte_ready=0, mem_write_enable=1, mem_addr=4*word_index (index from 0), mem_write_data=assembled word.
REQ-020 Write latency: mem_write_enable asserted in the cycle immediately after the 4th byte's handshake.
REQ-021 After WRITE: word_index+1 < N -> PAYLOAD with word_index incremented; else -> CHECK if checksum built, else DONE.
REQ-022 Cycles with byte_valid=0 SHALL not advance any counter; any number of stall cycles is legal.
REQ-023 mem_write_enable SHALL be 0 in every state except WRITE; mem_addr and mem_write_data hold their last values outside WRITE.
REQ-024 DONE: done=1 for one cycle, byte_ready=0, then -> IDLE; cpu_hold drops in the same cycle the state returns to IDLE.
REQ-025 Byte counter 2 bits, wraps 3->0; word index SHALL never exceed DEPTH-1.

Reset
REQ-026 reset=1 SHALL force IDLE and byte_ready=0, mem_write_enable=0, mem_addr=0, mem_write_data=0, cpu_hold=0, done=0, error=0, all counters and checksum to 0.
REQ-027 reset during a load SHALL abort it without a done pulse; words already written remain in memory.
REQ-028 reset takes priority over start and byte handshakes in the same cycle.

Configuration
REQ-029 Macro IMEM_LOADER_CHECKSUM_EN defined: a running 8-bit sum (mod 256) of all header and payload bytes is kept; CHECK accepts one byte (byte_ready=1) and, if it does not equal the two's complement of the sum, sets error=1; then -> DONE.
REQ-030 Macro not defined: no CHECK state, no checksum logic; the stream ends after the last payload byte and error is set only by REQ-017.

Verification
REQ-031 start, header 01 00 00 00, payload b3 03 53 00 -> one write, mem_addr=0, mem_write_data=32'h005303b3, done pulse, error=0, cpu_hold low afterwards.
REQ-032 N=3 with byte_valid toggled every other cycle -> writes at addresses 0, 4, 8 in order, each exactly one cycle, no byte lost or duplicated.
REQ-033 header 41 00 00 00 with DEPTH=64 -> no mem_write_enable, done=1 with error=1 right after header.
REQ-034 reset asserted after the 2nd payload word of N=4 -> outputs at reset values next cycle, no done; a subsequent start performs a clean full load.
REQ-035 start pulsed while in PAYLOAD -> ignored, load completes normally.
REQ-036 With IMEM_LOADER_CHECKSUM_EN: stream of REQ-031 plus correct checksum byte -> error=0; same stream with checksum+1 -> error=1, word still written.
